// File: rtl/timer_countdown.sv
// timer_countdown: BCD M:SS countdown with keypad shift-load, 1 Hz decrement and completion flags
module timer_countdown #(
  parameter int MIN_MAX = 9
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] d,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       enablen,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       zero,
  output logic       done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [3:0] MM = 4'(MIN_MAX);
  state_t state, state_nxt;
  logic loadn_q, tick_q;
  logic ld_ev, tk_ev, ld_ok, dec, last;
  logic [3:0] so_n, st_n, mo_n;
  assign ld_ev = !loadn && loadn_q;
  assign tk_ev = pgt_1Hz && !tick_q;
  assign zero  = {min_ones, sec_tens, sec_ones} == 12'h000;
  assign ld_ok = ld_ev && state != RUN && d <= 4'd9 && sec_ones <= 4'd5 && sec_tens <= MM;
  assign dec   = state == RUN && tk_ev && !zero;
  assign last  = dec && {min_ones, sec_tens, sec_ones} == 12'h001;
  // next digit values: a load shifts left, a tick borrows through the BCD digits
  always_comb begin
    so_n = sec_ones;
    st_n = sec_tens;
    mo_n = min_ones;
    if (ld_ok) begin
      mo_n = sec_tens;
      st_n = sec_ones;
      so_n = d;
    end else if (dec) begin
      if (sec_ones != 4'd0) so_n = sec_ones - 4'd1;
      else if (sec_tens != 4'd0) begin
        so_n = 4'd9;
        st_n = sec_tens - 4'd1;
      end else begin
        so_n = 4'd9;
        st_n = 4'd5;
        mo_n = min_ones - 4'd1;
      end
    end
  end
  // next state: reaching 0:00 wins over pausing; an idle count needs a non-zero value to start
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = (!enablen && !zero) ? RUN : IDLE;
      RUN:     state_nxt = (last || zero) ? IDLE : (enablen ? PAUSE : RUN);
      PAUSE:   state_nxt = enablen ? PAUSE : (zero ? IDLE : RUN);
      default: state_nxt = IDLE;
    endcase
  end
  // state, digits, edge detectors and the registered completion pulse
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= IDLE;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      loadn_q  <= 1'b1;
      tick_q   <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      sec_ones <= so_n;
      sec_tens <= st_n;
      min_ones <= mo_n;
      loadn_q  <= loadn;
      tick_q   <= pgt_1Hz;
      done     <= last;
    end
  end
endmodule

// File: tb/tb_timer_countdown.sv
// tb_timer_countdown: directed self-checking bench for the BCD countdown core
module tb_timer_countdown;
  logic clk = 1'b0, clearn = 1'b1, loadn = 1'b1, pgt_1Hz = 1'b0, enablen = 1'b1;
  logic [3:0] d = 4'd0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic zero, done;
  logic [11:0] cnt;
  int checks = 0, errors = 0;

  timer_countdown #(.MIN_MAX(9)) dut (
    .clk(clk), .clearn(clearn), .d(d), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .enablen(enablen), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .zero(zero), .done(done)
  );

  assign cnt = {min_ones, sec_tens, sec_ones};
  always #5 clk = ~clk;

  task automatic do_clear();
    @(negedge clk) clearn = 1'b0;
    #2 clearn = 1'b1;
  endtask

  task automatic press(input logic [3:0] v);
    @(negedge clk) d = v;
    loadn = 1'b0;
    repeat (3) @(negedge clk);
    loadn = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick(output logic dn);
    @(negedge clk) pgt_1Hz = 1'b1;
    @(negedge clk) dn = done;
    pgt_1Hz = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_clear();
    checks++;
    if (cnt !== 12'h000 || zero !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init got cnt=%h zero=%b done=%b exp cnt=000 zero=1 done=0", cnt, zero, done);
    end
    enablen = 1'b1;
    press(4'd3); press(4'd2); press(4'd7);
    enablen = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cnt !== 12'h327) begin errors++; $display("FAIL reset_preload got %h exp 327", cnt); end
    pgt_1Hz = 1'b1;
    #2 clearn = 1'b0;
    #1;
    checks++;
    if (cnt !== 12'h000 || zero !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got cnt=%h zero=%b done=%b exp cnt=000 zero=1 done=0", cnt, zero, done);
    end
    #1 clearn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cnt !== 12'h000 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got cnt=%h done=%b exp cnt=000 done=0", cnt, done);
    end
    pgt_1Hz = 1'b0;
    enablen = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    logic [3:0] digs [3] = '{4'd1, 4'd3, 4'd0};
    logic [11:0] exps [3] = '{12'h001, 12'h013, 12'h130};
    enablen = 1'b1;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) d = digs[i];
      loadn = 1'b0;
      @(negedge clk);
      checks++;
      if (cnt !== exps[i]) begin errors++; $display("FAIL load_first%0d got %h exp %h", i, cnt, exps[i]); end
      repeat (49) @(negedge clk);
      checks++;
      if (cnt !== exps[i]) begin errors++; $display("FAIL load_hold%0d got %h exp %h", i, cnt, exps[i]); end
      loadn = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reject();
    enablen = 1'b1;
    do_clear();
    press(4'd7);
    checks++;
    if (cnt !== 12'h007) begin errors++; $display("FAIL reject_pre got %h exp 007", cnt); end
    press(4'd2);
    checks++;
    if (cnt !== 12'h007) begin errors++; $display("FAIL reject_ones got %h exp 007", cnt); end
    do_clear();
    press(4'hC);
    checks++;
    if (cnt !== 12'h000 || zero !== 1'b1) begin
      errors++;
      $display("FAIL reject_digit got cnt=%h zero=%b exp cnt=000 zero=1", cnt, zero);
    end
  endtask

  task automatic test_countdown();
    logic dn;
    int s, pulses;
    logic [11:0] e;
    enablen = 1'b1;
    do_clear();
    press(4'd1); press(4'd0); press(4'd0);
    checks++;
    if (cnt !== 12'h100) begin errors++; $display("FAIL cd_load got %h exp 100", cnt); end
    enablen = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 60; k++) begin
      tick(dn);
      s = 60 - k;
      e = {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10)};
      if (dn === 1'b1) pulses++;
      checks++;
      if (cnt !== e || dn !== (s == 0)) begin
        errors++;
        $display("FAIL cd_tick%0d got cnt=%h done=%b exp cnt=%h done=%b", k, cnt, dn, e, s == 0);
      end
    end
    checks++;
    if (pulses != 1 || done !== 1'b0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL cd_done got pulses=%0d done=%b zero=%b exp pulses=1 done=0 zero=1", pulses, done, zero);
    end
    for (int k = 0; k < 3; k++) begin
      tick(dn);
      checks++;
      if (cnt !== 12'h000 || dn !== 1'b0) begin
        errors++;
        $display("FAIL cd_under%0d got cnt=%h done=%b exp cnt=000 done=0", k, cnt, dn);
      end
    end
    enablen = 1'b1;
  endtask

  task automatic test_pause();
    logic dn;
    enablen = 1'b1;
    do_clear();
    press(4'd4); press(4'd5);
    enablen = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cnt !== 12'h045) begin errors++; $display("FAIL pause_run got %h exp 045", cnt); end
    enablen = 1'b1;
    repeat (5) tick(dn);
    checks++;
    if (cnt !== 12'h045) begin errors++; $display("FAIL pause_hold got %h exp 045", cnt); end
    press(4'd3);
    checks++;
    if (cnt !== 12'h453) begin errors++; $display("FAIL pause_load got %h exp 453", cnt); end
    enablen = 1'b0;
    tick(dn);
    checks++;
    if (cnt !== 12'h452) begin errors++; $display("FAIL pause_resume got %h exp 452", cnt); end
    enablen = 1'b1;
  endtask

  task automatic test_simultaneous();
    logic dn;
    enablen = 1'b1;
    do_clear();
    press(4'd3); press(4'd0);
    enablen = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk) d = 4'd1;
    loadn = 1'b0;
    pgt_1Hz = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt !== 12'h029) begin errors++; $display("FAIL sim_run got %h exp 029", cnt); end
    loadn = 1'b1;
    pgt_1Hz = 1'b0;
    @(negedge clk);
    repeat (4) tick(dn);
    checks++;
    if (cnt !== 12'h025) begin errors++; $display("FAIL sim_run4 got %h exp 025", cnt); end
    enablen = 1'b1;
    repeat (2) @(negedge clk);
    @(negedge clk) d = 4'd1;
    loadn = 1'b0;
    pgt_1Hz = 1'b1;
    @(negedge clk);
    checks++;
    if (cnt !== 12'h251) begin errors++; $display("FAIL sim_pause got %h exp 251", cnt); end
    loadn = 1'b1;
    pgt_1Hz = 1'b0;
    @(negedge clk);
    tick(dn);
    checks++;
    if (cnt !== 12'h251) begin errors++; $display("FAIL sim_pause_tick got %h exp 251", cnt); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_reject();
    test_countdown();
    test_pause();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
- BCD countdown core (M:SS) that consumes the control_timer outputs: digit code `d`, active-low load strobe `loadn` and 1 Hz tick `pgt_1Hz`.
- Keypad digits shift in from the right. The count then decrements once per tick while counting is enabled.
- Flags completion for the display/buzzer logic downstream.

Parameters:
- MIN_MAX, 9, largest legal minutes digit. A load that would shift a larger value into `min_ones` is rejected.

Ports:
- `clk` in 1: system clock. All state changes on its rising edge.
- `clearn` in 1: asynchronous active-low reset.
- `d` in 4: BCD digit from the keypad encoder. Valid while `loadn`=0.
- `loadn` in 1: active-low load strobe. Synchronous to `clk`; may stay low for many cycles.
- `pgt_1Hz` in 1: 1 Hz tick, synchronous level. Its rising edge is one tick.
- `enablen` in 1: active-low count enable (0 = count, 1 = pause).
- `sec_ones` out 4: seconds units, BCD 0-9.
- `sec_tens` out 4: seconds tens, BCD 0-5.
- `min_ones` out 4: minutes, BCD 0-MIN_MAX.
- `zero` out 1: 1 when the count is 0:00.
- `done` out 1: one-cycle pulse when the count reaches 0:00 by decrement.

Behaviour:
- Reset (`clearn`=0, asynchronous):
  - All digits 0, `zero`=1, `done`=0, state IDLE.
  - Edge registers `loadn_q`=1 and `tick_q`=1, so no spurious edge appears after reset release.
- Edge detection:
  - `ld_ev` = (`loadn`==0 && `loadn_q`==1).
  - `tk_ev` = (`pgt_1Hz`==1 && `tick_q`==0).
  - Both edge registers sample every cycle.
  - Holding `loadn` low produces exactly one load.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: count is 0:00 or freshly cleared.
    - `ld_ev` loads a digit.
    - Go to RUN when `enablen`=0 and `zero`=0.
  - RUN:
    - `tk_ev` decrements the count.
    - `enablen`=1 goes to PAUSE.
    - Reaching 0:00 goes to IDLE.
    - `ld_ev` is ignored.
  - PAUSE:
    - `ld_ev` loads a digit.
    - `enablen`=0 returns to RUN if `zero`=0, else goes to IDLE.
    - Ticks are ignored.
- Load (IDLE/PAUSE only; takes effect on the cycle `ld_ev` is seen, so outputs change 1 clk after `loadn` falls):
  - Shift: `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`d`.
  - Rejected as a whole (no change) if any of these hold: `d`>9, old `sec_ones`>5, or old `sec_tens`>MIN_MAX.
- Decrement (RUN, `tk_ev`), evaluated in this order:
  - `sec_ones`>0: decrement it.
  - Else `sec_tens`>0: `sec_ones`=9 and decrement `sec_tens`.
  - Else `min_ones`>0: `sec_ones`=9, `sec_tens`=5, decrement `min_ones`.
  - Example: 1:00 → 0:59, 0:10 → 0:09.
- Completion: on the decrement 0:01 → 0:00, `zero`=1, `done`=1 for that following single cycle, state IDLE.
- Underflow: count never goes below 0:00. A tick at 0:00 does nothing and produces no `done`.
- `zero` is combinational from the registered digits; `done` is registered.
- Simultaneous events:
  - `ld_ev` and `tk_ev` in the same cycle: only the state-legal one acts (load in IDLE/PAUSE, tick in RUN).
  - `enablen` rising in the same cycle as `tk_ev` in RUN: the tick is still applied, then PAUSE.
- Reset mid-count: digits clear immediately (asynchronous), no `done` pulse.
- Digits are never outside BCD range under any input sequence.

Test Plan:
- Reset: assert `clearn`=0 mid-run at 3:27 → all digits 0, `zero`=1, `done`=0 with no `clk` edge. Release → no load or tick occurs until a fresh edge.
- Load: `enablen`=1; press 1, 3, 0, each with `loadn` low for 50 cycles → display 0:01, 0:13, 1:30. Each digit loads exactly once, 1 clk after `loadn` falls.
- Reject: at 0:07 load `d`=2 → stays 0:07 (7 cannot move into tens). `d`=4'hC at 0:00 → no change.
- Countdown: 1:00 loaded, `enablen`=0, ticks → 0:59, 0:58 … 0:00. `done` pulses once for 1 cycle. Further ticks keep 0:00, `done`=0.
- Pause: running at 0:45, set `enablen`=1 and give 5 ticks → stays 0:45. Load `d`=3 → 4:53. Set `enablen`=0 → resumes 4:52 on the next tick.
- Simultaneous: in RUN give `ld_ev` and `tk_ev` in the same cycle at 0:30 → 0:29, load ignored. In PAUSE the same stimulus → load applied, tick ignored.
